mcp3008_scan_ctrl: RTL



---
 rtl/microgreen_pkg.sv | 42 ++++
 rtl/mcp3008_frame_xfer.sv | 137 +++++++++++++
 rtl/mcp3008_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/microgreen_pkg.sv
// Shared encodings and MCP3008 frame constants for the sensor front end.
// Imported by the scan controller and its single-frame SPI engine.
package microgreen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_COMMIT
  } scan_state_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_SETUP,
    XF_SHIFT
  } xfer_state_t;

  localparam int MCP_FRAME_BITS    = 17;
  localparam int MCP_NULL_EDGE     = 7;
  localparam int MCP_DATA_MSB_EDGE = 8;
  localparam logic [1:0] MCP_CMD_SINGLE = 2'b11;

  // Index of the final SCLK half-period in a frame (low/high halves alternate).
  localparam int MCP_HALF_LAST = 2 * MCP_FRAME_BITS - 1;

  // MOSI level that must be valid at rising SCLK edge edge_num (1-based).
  function automatic logic mcp_cmd_bit(input logic [2:0] ch, input logic [4:0] edge_num);
    logic b;
    b = 1'b0;
    case (edge_num)
      5'd1:    b = MCP_CMD_SINGLE[1];
      5'd2:    b = MCP_CMD_SINGLE[0];
      5'd3:    b = ch[2];
      5'd4:    b = ch[1];
      5'd5:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mcp3008_frame_xfer.sv
// Single MCP3008 conversion frame: SPI mode 0, 17 SCLK periods, command out,
// null-bit check and 10-bit result capture (reported as the top 8 bits).
module mcp3008_frame_xfer
  import microgreen_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [2:0] ch,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk,
  output logic       cs_n,
  output logic       in_shift,
  output logic       fin,
  output logic [7:0] sample,
  output logic       null_err
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       HALF_LAST = 6'(MCP_HALF_LAST);

  xfer_state_t state_q, state_d;

  logic [DIV_W-1:0] div_q;
  logic [5:0]       half_q;
  logic [2:0]       ch_q;
  logic [9:0]       shreg_q;
  logic             null_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             cs_n_q;

  logic             tick;
  logic             rise;
  logic             fall;
  logic             finish;
  logic [4:0]       rise_num;
  logic [4:0]       next_num;

  always_comb begin
    state_d  = state_q;
    finish   = 1'b0;
    tick     = (div_q == DIV_LAST);
    rise     = 1'b0;
    fall     = 1'b0;
    rise_num = half_q[5:1] + 5'd1;
    next_num = half_q[5:1] + 5'd2;
    case (state_q)
      XF_IDLE: begin
        if (go) state_d = XF_SETUP;
      end
      XF_SETUP: begin
        if (tick) state_d = XF_SHIFT;
      end
      XF_SHIFT: begin
        if (tick) begin
          if (half_q == HALF_LAST) begin
            state_d = XF_IDLE;
            finish  = 1'b1;
          end else if (!half_q[0]) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
          end
        end
      end
      default: state_d = XF_IDLE;
    endcase
  end

  // MISO is captured on the same clk edge that raises SCLK; the ADC shifts on falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= XF_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      ch_q    <= '0;
      shreg_q <= '0;
      null_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      case (state_q)
        XF_IDLE: begin
          if (go) begin
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= mcp_cmd_bit(ch, 5'd1);
            ch_q    <= ch;
            div_q   <= '0;
            half_q  <= '0;
            shreg_q <= '0;
            null_q  <= 1'b0;
          end
        end
        XF_SETUP: begin
          div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
        XF_SHIFT: begin
          div_q <= tick ? '0 : div_q + DIV_W'(1);
          if (finish) begin
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
          end
          if (rise) begin
            sclk_q <= 1'b1;
            half_q <= half_q + 6'd1;
            if (rise_num == 5'(MCP_NULL_EDGE)) null_q <= miso;
            if (rise_num >= 5'(MCP_DATA_MSB_EDGE)) shreg_q <= {shreg_q[8:0], miso};
          end
          if (fall) begin
            sclk_q <= 1'b0;
            half_q <= half_q + 6'd1;
            mosi_q <= mcp_cmd_bit(ch_q, next_num);
          end
        end
        default: ;
      endcase
    end
  end

  assign mosi     = mosi_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign in_shift = (state_q == XF_SHIFT);
  assign fin      = finish;
  assign sample   = shreg_q[9:2];
  assign null_err = null_q;

endmodule

// File: rtl/mcp3008_scan_ctrl.sv
// MCP3008 scan sequencer: converts channels 0..NUM_CH-1 per trigger and commits
// all samples and null-bit flags to the datapath in a single cycle.
module mcp3008_scan_ctrl
  import microgreen_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int NUM_CH  = 4,
  parameter int CS_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done,
  output logic [8*NUM_CH-1:0]   sample_data,
  output logic [NUM_CH-1:0]     frame_err
);

  localparam int HOLD_W = $clog2(CS_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);
  localparam logic [2:0]        LAST_CH   = 3'(NUM_CH - 1);

  scan_state_t state_q, state_d;

  logic [2:0]          ch_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [8*NUM_CH-1:0] shadow_data;
  logic [NUM_CH-1:0]   shadow_err;
  logic [8*NUM_CH-1:0] sample_q;
  logic [NUM_CH-1:0]   err_q;
  logic                busy_q;
  logic                done_q;

  logic                go;
  logic [2:0]          go_ch;
  logic                accept;
  logic                hold_done;

  logic                xf_in_shift;
  logic                xf_fin;
  logic [7:0]          xf_sample;
  logic                xf_null;

  mcp3008_frame_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .ch       (go_ch),
    .miso     (miso),
    .mosi     (mosi),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .in_shift (xf_in_shift),
    .fin      (xf_fin),
    .sample   (xf_sample),
    .null_err (xf_null)
  );

  // The frame engine is launched on the same edge the scan state enters SETUP,
  // so frames abut the CS hold window with no extra handshake cycle.
  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    go_ch     = ch_q;
    accept    = 1'b0;
    hold_done = (hold_q == HOLD_LAST);
    case (state_q)
      ST_IDLE: begin
        if (start && ena) begin
          state_d = ST_SETUP;
          accept  = 1'b1;
          go      = 1'b1;
          go_ch   = 3'd0;
        end
      end
      ST_SETUP: begin
        if (xf_in_shift) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (xf_fin) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_done) begin
          if (ch_q == LAST_CH) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_SETUP;
            go      = 1'b1;
            go_ch   = ch_q + 3'd1;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      hold_q      <= '0;
      shadow_data <= '0;
      shadow_err  <= '0;
      sample_q    <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        ch_q   <= 3'd0;
        busy_q <= 1'b1;
      end
      if (state_q == ST_SHIFT && xf_fin) begin
        hold_q <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_q == 3'(k)) begin
            shadow_data[8*k +: 8] <= xf_sample;
            shadow_err[k]         <= xf_null;
          end
        end
      end
      if (state_q == ST_HOLD) begin
        hold_q <= hold_q + HOLD_W'(1);
        if (hold_done && ch_q != LAST_CH) ch_q <= ch_q + 3'd1;
      end
      // Outputs move together on this one edge so a consumer never sees a mixed scan.
      if (state_q == ST_COMMIT) begin
        sample_q <= shadow_data;
        err_q    <= shadow_err;
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_data = sample_q;
  assign frame_err   = err_q;

endmodule
